time_set_ctrl: RTL and testbench

Controller for the MM:SS seven-segment clock. It sequences four external BCD digit counters (sec ones mod-10, sec tens mod-6, min ones mod-10, min tens mod-6) by generating their enable, load and clear strobes. It runs a RUN/EDIT state machine driven by debounced key pulses, and drives the blanking mask that blinks the digit being edited. It sits between the key/tick generators and the digit counter bank.

---
 rtl/time_set_ctrl.sv | 150 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Strobe generator and RUN/EDIT controller for an MM:SS clock built from
// four external BCD digit counters. Digit 0 is sec ones, 1 is sec tens,
// 2 is min ones and 3 is min tens.
//
// Ports
//   clk, rst_n  : system clock, synchronous active-low reset
//   tick        : one-cycle 1 Hz pulse
//   key_mode    : enter edit / advance digit / leave edit (one-cycle pulse)
//   key_inc     : increment the selected digit while editing (one-cycle pulse)
//   key_clr     : clear all digits (one-cycle pulse)
//   q_digits    : current counter values, 4 bits per digit
//   en          : per-digit count enable
//   ld_n        : per-digit active-low load strobe
//   ld_data     : load value shared by all digits
//   clr_n       : active-low clear to all digits
//   sel         : digit under edit
//   blank       : per-digit blank mask (blinks the edited digit)
//   wrap        : one-cycle pulse on 59:59 -> 00:00
//   editing     : high while in EDIT
// Every output comes straight from a flop, so ld_n and clr_n are glitch-free.
module time_set_ctrl #(
  parameter logic [3:0] ONES_MAX = 4'd9,
  parameter logic [3:0] TENS_MAX = 4'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_clr,
  input  logic [15:0] q_digits,
  output logic [3:0]  en,
  output logic [3:0]  ld_n,
  output logic [3:0]  ld_data,
  output logic        clr_n,
  output logic [1:0]  sel,
  output logic [3:0]  blank,
  output logic        wrap,
  output logic        editing
);

  typedef enum logic {RUN, EDIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        phase_q, phase_d;
  logic [3:0]  en_q, en_d;
  logic [3:0]  ld_n_q, ld_n_d;
  logic [3:0]  ld_data_q, ld_data_d;
  logic        clr_n_q, clr_n_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  blank_q, blank_d;

  // Which digits currently sit at their terminal value. The cascade is
  // decoded from the counter values themselves rather than from counter
  // carries, which keeps the enable path free of combinational loops.
  logic [3:0] at_max;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_at_max
      localparam logic [3:0] DIGIT_MAX = (gi % 2 == 1) ? TENS_MAX : ONES_MAX;
      assign at_max[gi] = (q_digits[4*gi +: 4] == DIGIT_MAX);
    end
  endgenerate

  logic [3:0] sel_val;
  logic [3:0] sel_max;

  assign sel_val = q_digits[{sel_q, 2'b00} +: 4];
  assign sel_max = sel_q[0] ? TENS_MAX : ONES_MAX;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    phase_d   = phase_q;
    en_d      = 4'b0000;
    ld_n_d    = 4'hF;
    ld_data_d = ld_data_q;
    clr_n_d   = 1'b1;
    wrap_d    = 1'b0;

    // Only the highest-priority event of a cycle acts; the rest are dropped.
    if (key_clr) begin
      clr_n_d = 1'b0;
    end else if (key_mode) begin
      if (state_q == RUN) begin
        state_d = EDIT;
        sel_d   = 2'd3;
        phase_d = 1'b0;
      end else if (sel_q == 2'd0) begin
        state_d = RUN;
        phase_d = 1'b0;
      end else begin
        sel_d = sel_q - 2'd1;
      end
    end else if (key_inc && (state_q == EDIT)) begin
      ld_n_d[sel_q] = 1'b0;
      // Out-of-range values (e.g. 7 on a tens digit) also restart at 0.
      ld_data_d = (sel_val >= sel_max) ? 4'd0 : sel_val + 4'd1;
    end else if (tick) begin
      if (state_q == EDIT) begin
        phase_d = ~phase_q;
      end else begin
        en_d   = {&at_max[2:0], &at_max[1:0], at_max[0], 1'b1};
        wrap_d = &at_max;
      end
    end

    blank_d = 4'b0000;
    if ((state_d == EDIT) && phase_d) begin
      blank_d = 4'b0001 << sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sel_q     <= 2'd0;
      phase_q   <= 1'b0;
      en_q      <= 4'b0000;
      ld_n_q    <= 4'hF;
      ld_data_q <= 4'd0;
      clr_n_q   <= 1'b1;
      wrap_q    <= 1'b0;
      blank_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      phase_q   <= phase_d;
      en_q      <= en_d;
      ld_n_q    <= ld_n_d;
      ld_data_q <= ld_data_d;
      clr_n_q   <= clr_n_d;
      wrap_q    <= wrap_d;
      blank_q   <= blank_d;
    end
  end

  assign en      = en_q;
  assign ld_n    = ld_n_q;
  assign ld_data = ld_data_q;
  assign clr_n   = clr_n_q;
  assign sel     = sel_q;
  assign blank   = blank_q;
  assign wrap    = wrap_q;
  assign editing = (state_q == EDIT);

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, key_mode, key_inc, key_clr;
  logic [15:0] q_digits;
  logic [3:0]  en, ld_n, ld_data, blank;
  logic        clr_n, wrap, editing;
  logic [1:0]  sel;

  int checks = 0;
  int errors = 0;

  // Reference model state: clock mode, edited digit, blink phase.
  bit       m_edit;
  int       m_sel;
  bit       m_phase;
  bit [3:0] e_en, e_ld_n, e_ld_data, e_blank;
  bit       e_clr_n, e_wrap;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .key_clr  (key_clr),
    .q_digits (q_digits),
    .en       (en),
    .ld_n     (ld_n),
    .ld_data  (ld_data),
    .clr_n    (clr_n),
    .sel      (sel),
    .blank    (blank),
    .wrap     (wrap),
    .editing  (editing)
  );

  function automatic int dmax(input int idx);
    return (idx % 2 == 1) ? 5 : 9;
  endfunction

  function automatic int digit_of(input logic [15:0] q, input int idx);
    return int'((q >> (4 * idx)) & 16'hF);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the clock rules in plain terms.
  task automatic model_step(input bit r, input bit t, input bit m, input bit i,
                            input bit c, input logic [15:0] q);
    int d;
    bit all_max;
    e_en    = 4'h0;
    e_ld_n  = 4'hF;
    e_clr_n = 1'b1;
    e_wrap  = 1'b0;
    if (!r) begin
      m_edit = 0; m_sel = 0; m_phase = 0; e_ld_data = 4'h0;
    end else if (c) begin
      e_clr_n = 1'b0;
    end else if (m) begin
      if (!m_edit) begin
        m_edit = 1; m_sel = 3; m_phase = 0;
      end else if (m_sel == 0) begin
        m_edit = 0; m_phase = 0;
      end else begin
        m_sel = m_sel - 1;
      end
    end else if (i && m_edit) begin
      d = digit_of(q, m_sel);
      e_ld_data = (d >= dmax(m_sel)) ? 4'd0 : 4'(d + 1);
      e_ld_n[m_sel] = 1'b0;
    end else if (t) begin
      if (m_edit) begin
        m_phase = ~m_phase;
      end else begin
        // A digit counts when every digit below it is at its maximum.
        all_max = 1;
        for (int k = 0; k < 4; k++) begin
          if (all_max) e_en[k] = 1'b1;
          if (digit_of(q, k) != dmax(k)) all_max = 0;
        end
        e_wrap = all_max;
      end
    end
    e_blank = (m_edit && m_phase) ? 4'(1 << m_sel) : 4'h0;
  endtask

  task automatic step(input bit r, input bit t, input bit m, input bit i,
                      input bit c, input logic [15:0] q);
    rst_n = r; tick = t; key_mode = m; key_inc = i; key_clr = c; q_digits = q;
    @(posedge clk);
    model_step(r, t, m, i, c, q);
    #1;
    $display("step rst_n=%0b tick=%0b mode=%0b inc=%0b clr=%0b q=%h -> en=%b ld_n=%b ld_data=%h clr_n=%b sel=%0d blank=%b wrap=%b editing=%b",
             r, t, m, i, c, q, en, ld_n, ld_data, clr_n, sel, blank, wrap, editing);
    chk("en", 16'(en), 16'(e_en));
    chk("ld_n", 16'(ld_n), 16'(e_ld_n));
    chk("ld_data", 16'(ld_data), 16'(e_ld_data));
    chk("clr_n", 16'(clr_n), 16'(e_clr_n));
    chk("sel", 16'(sel), 16'(m_sel));
    chk("blank", 16'(blank), 16'(e_blank));
    chk("wrap", 16'(wrap), 16'(e_wrap));
    chk("editing", 16'(editing), 16'(m_edit));
  endtask

  function automatic logic [3:0] rnd_digit(input int mx);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 4'(mx);
    if (r == 9) return 4'($urandom_range(mx + 1, 15));
    return 4'($urandom_range(0, mx));
  endfunction

  function automatic logic [15:0] rnd_q();
    return {rnd_digit(5), rnd_digit(9), rnd_digit(5), rnd_digit(9)};
  endfunction

  initial begin
    // Reset held for three cycles while every key is pulsed.
    for (int n = 0; n < 3; n++) step(0, 1, 1, 1, 1, 16'h5959);
    chk("reset_ld_n_const", 16'(ld_n), 16'hF);
    step(1, 0, 0, 0, 0, 16'h0000);

    // Cascade.
    step(1, 1, 0, 0, 0, 16'h5959);
    chk("cascade_full_en", 16'(en), 16'hF);
    chk("cascade_full_wrap", 16'(wrap), 16'h1);
    step(1, 1, 0, 0, 0, 16'h0309);
    chk("cascade_part_en", 16'(en), 16'h3);
    step(1, 1, 0, 0, 0, 16'h0000);

    // Edit walk with ticks while editing.
    step(1, 0, 1, 0, 0, 16'h1234);
    step(1, 1, 0, 0, 0, 16'h5959);
    chk("edit_tick_blank", 16'(blank), 16'h8);
    step(1, 1, 0, 0, 0, 16'h5959);
    step(1, 0, 1, 0, 0, 16'h1234);
    step(1, 1, 0, 0, 0, 16'h1234);
    step(1, 0, 1, 0, 0, 16'h1234);
    step(1, 0, 1, 0, 0, 16'h1234);
    step(1, 0, 1, 0, 0, 16'h1234);
    chk("edit_exit_editing", 16'(editing), 16'h0);

    // Increment wrap and back-to-back increments.
    step(1, 0, 1, 0, 0, 16'h0000);
    step(1, 0, 1, 0, 0, 16'h0000);
    step(1, 0, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 1, 0, 16'h0050);
    chk("inc_tens_ld_n", 16'(ld_n), 16'hD);
    chk("inc_tens_data", 16'(ld_data), 16'h0);
    step(1, 0, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 1, 0, 16'h0004);
    chk("inc_ones_data", 16'(ld_data), 16'h5);
    step(1, 0, 0, 1, 0, 16'h0005);
    step(1, 1, 0, 0, 0, 16'h0006);
    step(1, 0, 1, 0, 0, 16'h0006);
    step(1, 0, 1, 0, 0, 16'h7000);
    step(1, 0, 0, 1, 0, 16'h7000);
    chk("inc_oor_data", 16'(ld_data), 16'h0);

    // Simultaneous keys.
    step(1, 1, 1, 0, 1, 16'h5959);
    chk("simul_clr_n", 16'(clr_n), 16'h0);
    step(1, 0, 1, 1, 0, 16'h5959);
    step(1, 0, 0, 0, 0, 16'h5959);

    // Reset in the middle of an edit (currently at sel=2).
    step(1, 0, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0000);
    chk("rst_mid_edit_sel", 16'(sel), 16'h0);
    step(1, 0, 0, 0, 0, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 14) == 0),
           rnd_q());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
